corescore_reset_sequencer: RTL
==============================

Name: corescore_reset_sequencer

Overview:
- Consumes the reset produced by the board clock generator and releases it to the CoreScore fabric in a fixed order.
- Holds every reset domain for a minimum time, then releases the domains one at a time with a fixed gap, then flags ready.
- Domain order: interconnect, emitter/UART, core array rows.
- Also accepts a software reset request that re-runs the whole sequence.

Parameters:
- NUM_DOMAINS, 4, number of staged reset outputs; legal range 1..16.
- HOLD_CYCLES, 16, minimum cycles all domains stay in reset after i_rst deasserts; must be ≥1.
- STAGE_GAP, 8, cycles between consecutive domain releases; must be ≥1.

Ports:
- i_clk  input  1  fabric clock (output clock of the clock generator)
- i_rst  input  1  synchronous active-high reset (clock generator reset output)
- i_sw_rst  input  1  software reset request, level-sensitive, synchronous to i_clk
- o_rst  output  NUM_DOMAINS  per-domain active-high reset; bit 0 released first
- o_ready  output  1  high once every domain has been released
- o_busy  output  1  high while the sequence is in progress (not DONE)

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high, on i_rst. No asynchronous logic.
- State machine with three states: HOLD, STAGE, DONE. Single down/up counter sized with $clog2(max(HOLD_CYCLES, STAGE_GAP)+1). Stage index sized with $clog2(NUM_DOMAINS+1).
- While i_rst=1:
  - state=HOLD, counter=0, stage=0.
  - o_rst = all ones, o_ready=0, o_busy=1.
- HOLD:
  - Counter increments every cycle.
  - Edge numbering: edge 1 is the first edge with i_rst=0.
  - On edge HOLD_CYCLES, o_rst[0] deasserts, the counter clears and the state moves to STAGE with stage=1.
- STAGE:
  - Counter increments every cycle.
  - When the counter reaches STAGE_GAP, o_rst[stage] deasserts on that edge, the counter clears and stage increments.
  - After o_rst[NUM_DOMAINS-1] is released, the next edge enters DONE.
  - Result: o_rst[k] falls on edge HOLD_CYCLES + k*STAGE_GAP.
- DONE:
  - o_ready=1, o_busy=0, o_rst all zeros.
  - o_ready rises on edge HOLD_CYCLES + (NUM_DOMAINS-1)*STAGE_GAP + 1.
- NUM_DOMAINS=1: DONE is entered on edge HOLD_CYCLES+1.
- Released bits stay released. A bit changes only 1→0 during a sequence. Bits never glitch back to 1 except through reset or a restart.
- i_sw_rst=1 in any state (with i_rst=0):
  - Next edge: o_rst all ones, o_ready=0, o_busy=1, state=HOLD, counter=0, stage=0.
  - While i_sw_rst stays high, the counter is held at 0.
  - The sequence restarts from edge 1 on the first edge with i_sw_rst=0.
- Simultaneous events: i_rst has priority over i_sw_rst. i_sw_rst has priority over any stage release on the same edge.
- i_rst asserted mid-sequence: all domains are re-asserted on the next edge and the sequence restarts fully. Partial progress is not retained.
- Counters never wrap. The counter is cleared before it can exceed its compare value.

Optional Feature:
- Macro: CORESCORE_RSTSEQ_STATS_EN.
- With the macro defined:
  - Extra port o_restarts, output, 8 bits.
  - Counts completed i_sw_rst restarts: increments on the edge where i_sw_rst goes 0→1, sampled with a registered copy of i_sw_rst.
  - Saturates at 255.
  - Cleared only by i_rst.
  - Reset value 0.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Default parameters; deassert i_rst before edge 1 → o_rst[0..3] fall on edges 16/24/32/40, o_ready rises on edge 41, o_busy falls on edge 41.
- Reach DONE, then pulse i_sw_rst for 3 cycles → o_rst=4'b1111 and o_ready=0 on the next edge; after i_sw_rst falls, o_rst[0] falls 16 edges later.
- Assert i_rst for 1 cycle immediately after o_rst[1] releases (edge 25) → o_rst=4'b1111 on the next edge; full sequence replays with identical timing.
- i_rst=1 and i_sw_rst=1 together, then i_rst drops while i_sw_rst stays high for 10 cycles → no release until 16 edges after i_sw_rst falls.
- NUM_DOMAINS=1, HOLD_CYCLES=1, STAGE_GAP=1 → o_rst[0] falls on edge 1, o_ready rises on edge 2.
- CORESCORE_RSTSEQ_STATS_EN defined; 300 i_sw_rst pulses → o_restarts saturates at 255; asserting i_rst → o_restarts=0.

Source files
------------

// File: rtl/corescore_reset_sequencer.sv
// Staged reset release for the CoreScore fabric: hold all domains, then free them one by one.
// Optional restart counter port o_restarts is built when CORESCORE_RSTSEQ_STATS_EN is defined.
module corescore_reset_sequencer #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_sw_rst,
    output logic [NUM_DOMAINS-1:0] o_rst,
    output logic                   o_ready,
`ifdef CORESCORE_RSTSEQ_STATS_EN
    output logic [7:0]             o_restarts,
`endif
    output logic                   o_busy
);

    localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned STAGE_W = $clog2(NUM_DOMAINS + 1);

    typedef enum logic [1:0] {
        StHold,
        StStage,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STAGE_W-1:0]     stage_q, stage_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;

    logic                   hold_done;
    logic                   gap_done;
    logic                   all_released;
    logic [NUM_DOMAINS-1:0] stage_mask;

    // Compare against target-1 so the release lands on the edge the count reaches target.
    assign hold_done    = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign gap_done     = (cnt_q == CNT_W'(STAGE_GAP - 1));
    assign all_released = (stage_q == STAGE_W'(NUM_DOMAINS));

    always_comb begin
        stage_mask = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            stage_mask[i] = (stage_q == STAGE_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_d   = rst_q;

        if (i_sw_rst) begin
            // Software request beats any release due on this edge.
            state_d = StHold;
            cnt_d   = '0;
            stage_d = '0;
            rst_d   = '1;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (hold_done) begin
                        rst_d[0] = 1'b0;
                        cnt_d    = '0;
                        stage_d  = STAGE_W'(1);
                        state_d  = StStage;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StStage: begin
                    if (all_released) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else if (gap_done) begin
                        rst_d   = rst_q & ~stage_mask;
                        cnt_d   = '0;
                        stage_d = stage_q + STAGE_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    rst_d = '0;
                    cnt_d = '0;
                end
                default: begin
                    state_d = StHold;
                    cnt_d   = '0;
                    stage_d = '0;
                    rst_d   = '1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StHold;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_q   <= rst_d;
        end
    end

    assign o_rst   = rst_q;
    assign o_ready = (state_q == StDone);
    assign o_busy  = (state_q != StDone);

`ifdef CORESCORE_RSTSEQ_STATS_EN
    logic       sw_rst_q;
    logic [7:0] restarts_q, restarts_d;

    always_comb begin
        restarts_d = restarts_q;
        if (i_sw_rst && !sw_rst_q && (restarts_q != 8'hFF)) begin
            restarts_d = restarts_q + 8'd1;
        end
    end

    // The sampled copy keeps tracking during i_rst so a request held across reset is not recounted.
    always_ff @(posedge i_clk) begin
        sw_rst_q <= i_sw_rst;
        if (i_rst) begin
            restarts_q <= 8'd0;
        end else begin
            restarts_q <= restarts_d;
        end
    end

    assign o_restarts = restarts_q;
`endif

endmodule
